// File: rtl/cim_pkg.sv
// Shared constants and lane helper for the
// compute-in-memory GeMM macro.
package cim_pkg;

  localparam int CIM_WORD_W = 32;
  localparam int CIM_LANES  = 4;
  localparam int CIM_LANE_W = 8;
  localparam int CIM_NUM_OUT = 16;

  function automatic logic signed [CIM_LANE_W-1:0] cim_lane(
    input logic [CIM_WORD_W-1:0] word,
    input int                    idx
  );
    return word[idx*CIM_LANE_W +: CIM_LANE_W];
  endfunction

endpackage

// File: rtl/cim_dot4.sv
// Signed 4-lane int8 multiply-add, result
// sign-extended to a full word.
module cim_dot4
  import cim_pkg::*;
(
  input  logic [CIM_WORD_W-1:0] w,
  input  logic [CIM_WORD_W-1:0] x,
  output logic [CIM_WORD_W-1:0] d
);

  logic signed [15:0] prod [CIM_LANES];
  logic signed [17:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < CIM_LANES; i++) begin
      prod[i] = 16'(cim_lane(w, i)) *
                16'(cim_lane(x, i));
      sum = sum + 18'(prod[i]);
    end
    d = 32'(sum);
  end

endmodule

// File: rtl/basic_gemm_cim.sv
// CIM side-port macro: weight rows, dot-product
// engine and a file of 16 accumulators.
module basic_gemm_cim
  import cim_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int NUM_OUT = CIM_NUM_OUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  write,
  input  logic                  cim,
  input  logic                  partial_sum,
  input  logic                  reset_output,
  input  logic [3:0]            output_reg,
  input  logic [CIM_WORD_W-1:0] address,
  input  logic [CIM_WORD_W-1:0] input_data,
  output logic [CIM_WORD_W-1:0] cim_output
);

  logic [CIM_WORD_W-1:0] w_mem [DEPTH];
  logic [CIM_WORD_W-1:0] acc   [NUM_OUT];
  logic [CIM_WORD_W-1:0] w_row;
  logic [CIM_WORD_W-1:0] dot;
  logic [ADDR_W-1:0]     row;
  logic                  unused_addr;

  assign row         = address[ADDR_W-1:0];
  assign unused_addr = ^address[CIM_WORD_W-1:ADDR_W];

  // Read before the write lands, so a same-cycle
  // write+cim sees the old row.
  assign w_row = w_mem[row];

  cim_dot4 u_dot (
    .w (w_row),
    .x (input_data),
    .d (dot)
  );

  always_ff @(posedge clk) begin
    if (rst_n && cs && write)
      w_mem[row] <= input_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++)
        acc[i] <= '0;
    end else if (cs) begin
      if (reset_output) begin
        for (int i = 0; i < NUM_OUT; i++)
          acc[i] <= '0;
        if (cim)
          acc[output_reg] <= dot;
      end else if (cim) begin
        if (partial_sum)
          acc[output_reg] <= acc[output_reg] + dot;
        else
          acc[output_reg] <= dot;
      end
    end
  end

  assign cim_output = acc[output_reg];

endmodule

// File: tb/tb_basic_gemm_cim.sv
// Directed bench for basic_gemm_cim with
// hand-computed expected accumulator values.
module tb_basic_gemm_cim;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        write;
  logic        cim;
  logic        partial_sum;
  logic        reset_output;
  logic [3:0]  output_reg;
  logic [31:0] address;
  logic [31:0] input_data;
  logic [31:0] cim_output;

  int tests;
  int fails;

  basic_gemm_cim dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (cs),
    .write        (write),
    .cim          (cim),
    .partial_sum  (partial_sum),
    .reset_output (reset_output),
    .output_reg   (output_reg),
    .address      (address),
    .input_data   (input_data),
    .cim_output   (cim_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    write        = 1'b0;
    cim          = 1'b0;
    partial_sum  = 1'b0;
    reset_output = 1'b0;
  endtask

  task automatic do_cmd(
    input logic        c_cs,
    input logic        c_wr,
    input logic        c_cim,
    input logic        c_ps,
    input logic        c_ro,
    input logic [3:0]  c_reg,
    input logic [31:0] c_addr,
    input logic [31:0] c_data
  );
    cs           = c_cs;
    write        = c_wr;
    cim          = c_cim;
    partial_sum  = c_ps;
    reset_output = c_ro;
    output_reg   = c_reg;
    address      = c_addr;
    input_data   = c_data;
    @(posedge clk);
    #1;
    idle();
    cs = 1'b1;
  endtask

  task automatic check(
    input string       tag,
    input logic [3:0]  sel,
    input logic [31:0] exp
  );
    output_reg = sel;
    @(negedge clk);
    tests++;
    assert (cim_output === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h",
             tag, cim_output, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    cs = 1'b0;
    idle();
    output_reg = 4'd0;
    address    = '0;
    input_data = '0;

    for (int i = 0; i < 16; i++)
      check("rst_sweep", 4'(i), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cs    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst", 4'd9, 32'h0);

    // basic dot product
    do_cmd(1, 1, 0, 0, 0, 0, 32'd0, 32'h04030201);
    do_cmd(1, 0, 1, 0, 0, 3, 32'd0, 32'h01010101);
    check("dot_basic", 4'd3, 32'h0000000A);
    check("acc2_zero", 4'd2, 32'h0);

    // signed and accumulate; upper addr bits ignored
    do_cmd(1, 0, 1, 0, 0, 5, 32'hFFFF_FFC0,
           32'hFFFFFFFF);
    check("dot_neg", 4'd5, 32'hFFFFFFF6);
    do_cmd(1, 0, 1, 1, 0, 5, 32'd0, 32'hFFFFFFFF);
    check("acc_neg", 4'd5, 32'hFFFFFFEC);

    // extremes and wrap
    do_cmd(1, 1, 0, 0, 0, 0, 32'd1, 32'h80808080);
    do_cmd(1, 0, 1, 0, 0, 4, 32'd1, 32'h80808080);
    check("dot_max", 4'd4, 32'h00010000);
    do_cmd(1, 1, 0, 0, 0, 0, 32'd3, 32'h00000001);
    do_cmd(1, 0, 1, 0, 0, 9, 32'd3, 32'h000000FF);
    check("preload_m1", 4'd9, 32'hFFFFFFFF);
    do_cmd(1, 0, 1, 1, 0, 9, 32'd3, 32'h00000001);
    check("wrap", 4'd9, 32'h00000000);

    // cs gating
    do_cmd(0, 1, 1, 1, 0, 3, 32'd0, 32'h00000000);
    check("cs_acc", 4'd3, 32'h0000000A);
    do_cmd(1, 0, 1, 0, 0, 6, 32'd0, 32'h01010101);
    check("cs_wmem", 4'd6, 32'h0000000A);

    // write+cim same row uses old weights
    do_cmd(1, 1, 0, 0, 0, 0, 32'd2, 32'h02020202);
    do_cmd(1, 1, 1, 0, 0, 7, 32'd2, 32'h01010101);
    check("wr_cim_old", 4'd7, 32'h00000008);
    do_cmd(1, 0, 1, 0, 0, 7, 32'd2, 32'h01010101);
    check("wr_cim_new", 4'd7, 32'h00000004);

    // partial_sum ignored without cim
    do_cmd(1, 0, 0, 1, 0, 7, 32'd2, 32'h01010101);
    check("ps_only", 4'd7, 32'h00000004);

    // reset_output with cim
    do_cmd(1, 1, 0, 0, 0, 0, 32'd4, 32'h00000007);
    do_cmd(1, 1, 0, 0, 0, 0, 32'd5, 32'h00000009);
    do_cmd(1, 1, 0, 0, 0, 0, 32'd6, 32'h00000003);
    do_cmd(1, 0, 1, 0, 0, 0, 32'd4, 32'h00000001);
    do_cmd(1, 0, 1, 0, 0, 1, 32'd5, 32'h00000001);
    check("pre_ro0", 4'd0, 32'h00000007);
    check("pre_ro1", 4'd1, 32'h00000009);
    do_cmd(1, 0, 1, 1, 1, 1, 32'd6, 32'h00000001);
    check("ro_acc0", 4'd0, 32'h0);
    check("ro_acc1", 4'd1, 32'h00000003);
    check("ro_acc5", 4'd5, 32'h0);
    check("ro_acc3", 4'd3, 32'h0);

    // async reset mid-accumulation
    do_cmd(1, 0, 1, 0, 0, 8, 32'd0, 32'h01010101);
    check("pre_arst", 4'd8, 32'h0000000A);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    assert (cim_output === 32'h0) else begin
      fails++;
      $error("FAIL arst_now: got %h want %h",
             cim_output, 32'h0);
    end
    cim         = 1'b1;
    partial_sum = 1'b1;
    address     = 32'd0;
    input_data  = 32'h01010101;
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_lost", 4'd8, 32'h0);
    check("arst_acc1", 4'd1, 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
